// File: rtl/cmsdk_mcu_rst_seq.sv
// Staged reset sequencer: maskable reset requests, minimum-width HRESETn, delayed PRESETn, sticky cause.
// Optional CMSDK_RST_SEQ_SYNC_EN adds a 2-flop synchroniser on RSTREQ ahead of masking.
module cmsdk_mcu_rst_seq #(
    parameter int unsigned NUM_SRC   = 4,
    parameter int unsigned HOLD_CYC  = 16,
    parameter int unsigned STAGE_GAP = 4,
    parameter int unsigned CW        = 8
) (
    input  logic               HCLK,
    input  logic               HRESET,
    input  logic [NUM_SRC-1:0] RSTREQ,
    input  logic [NUM_SRC-1:0] RSTREQ_MASK,
    input  logic               CAUSE_CLR,
    output logic               HRESETn,
    output logic               PRESETn,
    output logic               RST_BUSY,
    output logic [NUM_SRC-1:0] RSTCAUSE,
    output logic               POR_FLAG
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ASSERT,
        ST_REL_H
    } state_t;

    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYC - 1);
    localparam logic [CW-1:0] GAP_LAST  = (STAGE_GAP == 0) ? '0 : CW'(STAGE_GAP - 1);

    state_t             state;
    state_t             state_nxt;
    logic [CW-1:0]      cnt;
    logic [CW-1:0]      cnt_nxt;
    logic [NUM_SRC-1:0] req_raw;
    logic [NUM_SRC-1:0] req;
    logic               any_req;

`ifdef CMSDK_RST_SEQ_SYNC_EN
    logic [NUM_SRC-1:0] sync_1;
    logic [NUM_SRC-1:0] sync_2;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            sync_1 <= '0;
            sync_2 <= '0;
        end else begin
            sync_1 <= RSTREQ;
            sync_2 <= sync_1;
        end
    end

    assign req_raw = sync_2;
`else
    assign req_raw = RSTREQ;
`endif

    assign req     = req_raw & RSTREQ_MASK;
    assign any_req = |req;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    state_nxt = ST_ASSERT;
                    cnt_nxt   = '0;
                end
            end
            ST_ASSERT: begin
                // A request present at terminal count stretches the hold with cnt frozen.
                if (cnt == HOLD_LAST) begin
                    if (!any_req) begin
                        state_nxt = (STAGE_GAP == 0) ? ST_IDLE : ST_REL_H;
                        cnt_nxt   = '0;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ST_REL_H: begin
                if (any_req) begin
                    state_nxt = ST_ASSERT;
                    cnt_nxt   = '0;
                end else if (cnt == GAP_LAST) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = ST_ASSERT;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state    <= ST_ASSERT;
            cnt      <= '0;
            HRESETn  <= 1'b0;
            PRESETn  <= 1'b0;
            RST_BUSY <= 1'b1;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            HRESETn  <= (state_nxt != ST_ASSERT);
            PRESETn  <= (state_nxt == ST_IDLE);
            RST_BUSY <= (state_nxt != ST_IDLE);
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            RSTCAUSE <= '0;
            POR_FLAG <= 1'b1;
        end else begin
            RSTCAUSE <= (CAUSE_CLR ? '0 : RSTCAUSE) | req;
            if (CAUSE_CLR) begin
                POR_FLAG <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cmsdk_mcu_rst_seq.sv
// Self-checking bench for cmsdk_mcu_rst_seq: directed scenarios plus random traffic against a
// timestamp-based reference model.
module tb_cmsdk_mcu_rst_seq;

    localparam int NSRC = 4;
    localparam int HOLD = 16;
    localparam int GAP  = 4;

    logic            HCLK = 1'b0;
    logic            HRESET;
    logic [NSRC-1:0] RSTREQ;
    logic [NSRC-1:0] RSTREQ_MASK;
    logic            CAUSE_CLR;
    logic            HRESETn;
    logic            PRESETn;
    logic            RST_BUSY;
    logic [NSRC-1:0] RSTCAUSE;
    logic            POR_FLAG;

    always #5 HCLK = ~HCLK;

    cmsdk_mcu_rst_seq #(
        .NUM_SRC  (NSRC),
        .HOLD_CYC (HOLD),
        .STAGE_GAP(GAP),
        .CW       (8)
    ) dut (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .RSTREQ     (RSTREQ),
        .RSTREQ_MASK(RSTREQ_MASK),
        .CAUSE_CLR  (CAUSE_CLR),
        .HRESETn    (HRESETn),
        .PRESETn    (PRESETn),
        .RST_BUSY   (RST_BUSY),
        .RSTCAUSE   (RSTCAUSE),
        .POR_FLAG   (POR_FLAG)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int t        = 0;

    // Reference model: release times as absolute cycle stamps.
    bit              m_h = 1'b0;
    bit              m_p = 1'b0;
    int              hold_until = 0;
    int              p_until = 0;
    logic [NSRC-1:0] m_cause = '0;
    bit              m_por = 1'b0;
    logic [NSRC-1:0] s1 = '0;
    logic [NSRC-1:0] s2 = '0;

    int lo_h = 0;
    int lo_p = 0;
    int busy_n = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, t);
        end
    endtask

    task automatic model_step();
        logic [NSRC-1:0] raw;
        logic [NSRC-1:0] req;
`ifdef CMSDK_RST_SEQ_SYNC_EN
        raw = s2;
        if (HRESET) begin
            s1 = '0;
            s2 = '0;
        end else begin
            s2 = s1;
            s1 = RSTREQ;
        end
`else
        raw = RSTREQ;
`endif
        req = raw & RSTREQ_MASK;
        if (HRESET) begin
            m_h = 1'b0;
            m_p = 1'b0;
            hold_until = t + HOLD;
            m_cause = '0;
            m_por = 1'b1;
        end else begin
            if (CAUSE_CLR) begin
                m_cause = '0;
                m_por = 1'b0;
            end
            m_cause = m_cause | req;
            if (|req) begin
                if (m_h) begin
                    m_h = 1'b0;
                    m_p = 1'b0;
                    hold_until = t + HOLD;
                end
            end else if (!m_h) begin
                if (t >= hold_until) begin
                    m_h = 1'b1;
                    p_until = t + GAP;
                    if (GAP == 0) m_p = 1'b1;
                end
            end else if (!m_p && t >= p_until) begin
                m_p = 1'b1;
            end
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        model_step();
        t++;
        #1;
        check_eq("HRESETn", HRESETn, m_h);
        check_eq("PRESETn", PRESETn, m_p);
        check_eq("RST_BUSY", RST_BUSY, !(m_h && m_p));
        check_eq("RSTCAUSE", RSTCAUSE, m_cause);
        check_eq("POR_FLAG", POR_FLAG, m_por);
        if (HRESETn === 1'b0) lo_h++;
        if (PRESETn === 1'b0) lo_p++;
        if (RST_BUSY === 1'b1) busy_n++;
    endtask

    task automatic clear_counts();
        lo_h = 0;
        lo_p = 0;
        busy_n = 0;
    endtask

    task automatic wait_idle(input int max_cyc);
        int k = 0;
        while (RST_BUSY !== 1'b0 && k < max_cyc) begin
            tick();
            k++;
        end
        check_eq("wait_idle", RST_BUSY, 1'b0);
    endtask

    task automatic wait_h_release(input int max_cyc);
        int k = 0;
        while (HRESETn !== 1'b1 && k < max_cyc) begin
            tick();
            k++;
        end
        check_eq("wait_hrelease", HRESETn, 1'b1);
    endtask

    initial begin
        logic [NSRC-1:0] saved_cause;
        logic [NSRC-1:0] bbits;
        int burst;

        HRESET = 1'b1;
        RSTREQ = '0;
        RSTREQ_MASK = '1;
        CAUSE_CLR = 1'b0;
        bbits = '0;
        burst = 0;

        // Power-on reset, then the staged release.
        repeat (3) tick();
        check_eq("por_flag_reset", POR_FLAG, 1'b1);
        check_eq("cause_reset", RSTCAUSE, 4'b0000);
        HRESET = 1'b0;
        clear_counts();
        repeat (25) tick();
        check_eq("t1_hlow", lo_h, HOLD - 1);
        check_eq("t1_plow", lo_p, HOLD + GAP - 1);

        // Single-cycle watchdog request.
        clear_counts();
        RSTREQ = 4'b0010;
        tick();
        RSTREQ = '0;
        repeat (40) tick();
        check_eq("t2_hlow", lo_h, HOLD);
        check_eq("t2_plow", lo_p, HOLD + GAP);
        check_eq("t2_busy", busy_n, HOLD + GAP);
        check_eq("t2_cause", RSTCAUSE, 4'b0010);

        // Long request stretches the hold.
        clear_counts();
        RSTREQ = 4'b0001;
        repeat (40) tick();
        RSTREQ = '0;
        repeat (60) tick();
        check_eq("t3_hlow", lo_h, 40);
        check_eq("t3_plow", lo_p, 40 + GAP);

        // Request during the HRESETn-to-PRESETn gap restarts a full hold.
        RSTREQ = 4'b0001;
        tick();
        RSTREQ = '0;
        wait_h_release(60);
        clear_counts();
        RSTREQ = 4'b1000;
        tick();
        RSTREQ = '0;
        repeat (40) tick();
        check_eq("t4_hlow", lo_h, HOLD);
        check_eq("t4_cause3", RSTCAUSE[3], 1'b1);

        // Masked source.
        wait_idle(60);
        RSTREQ_MASK = 4'b1110;
        saved_cause = m_cause;
        clear_counts();
        RSTREQ = 4'b0001;
        tick();
        RSTREQ = '0;
        repeat (10) tick();
        check_eq("t5_hlow", lo_h, 0);
        check_eq("t5_busy", busy_n, 0);
        check_eq("t5_cause", RSTCAUSE, saved_cause);
        RSTREQ_MASK = '1;

        // Set-vs-clear priority, then HRESET mid-hold.
        HRESET = 1'b1;
        repeat (2) tick();
        HRESET = 1'b0;
        RSTREQ = 4'b0011;
        tick();
        RSTREQ = '0;
        wait_idle(60);
        check_eq("t6_cause_pre", RSTCAUSE, 4'b0011);
        CAUSE_CLR = 1'b1;
        RSTREQ = 4'b0100;
        tick();
        CAUSE_CLR = 1'b0;
        RSTREQ = '0;
        repeat (4) tick();
        check_eq("t6_cause", RSTCAUSE, 4'b0100);
        check_eq("t6_por", POR_FLAG, 1'b0);
        clear_counts();
        HRESET = 1'b1;
        tick();
        HRESET = 1'b0;
        repeat (30) tick();
        check_eq("t6_hlow", lo_h, HOLD);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            HRESET = ($urandom_range(0, 399) == 0);
            CAUSE_CLR = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 99) == 0) RSTREQ_MASK = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 199) == 0) RSTREQ_MASK = '1;
            if (burst == 0 && $urandom_range(0, 39) == 0) begin
                burst = $urandom_range(1, 45);
                bbits = 4'($urandom_range(1, 15));
            end
            RSTREQ = (burst > 0) ? bbits : 4'h0;
            if (burst > 0) burst--;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
